// File: rtl/axi_mst_pkg.sv
// Shared constants, CRC-mode encodings and FSM state type for the AXI3 write master.
package axi_mst_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    localparam logic [2:0] CRC_MODE_NONE = 3'b000;
    localparam logic [2:0] CRC_MODE_8    = 3'b001;
    localparam logic [2:0] CRC_MODE_16   = 3'b010;
    localparam logic [2:0] CRC_MODE_32   = 3'b011;

    localparam int unsigned BOUNDARY_4K = 4096;

    typedef enum logic [3:0] {
        S_IDLE, S_CALC, S_AW, S_W, S_B,
        S_CRC_WAIT, S_CRC_AW, S_CRC_W, S_CRC_B, S_DONE
    } state_e;

    // Width of the appended CRC in bytes; 0 means no CRC write.
    function automatic logic [2:0] crc_bytes(input logic [2:0] mode);
        case (mode)
            CRC_MODE_8:  return 3'd1;
            CRC_MODE_16: return 3'd2;
            CRC_MODE_32: return 3'd4;
            default:     return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/axi_mst_write_burst_calc.sv
// Combinational burst sizing: clips the next burst to the remaining payload,
// the 4 KB page and MAX_BURST, and derives the final-beat byte strobes.
module axi_burst_calc
    import axi_mst_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 16
) (
    input  logic [11:0]         i_addr_lo,
    input  logic [15:0]         i_bytes_left,
    output logic [3:0]          o_awlen,
    output logic                o_last_burst,
    output logic [DATA_W/8-1:0] o_last_wstrb
);
    localparam int          BYTES     = DATA_W / 8;
    localparam int          LB        = $clog2(BYTES);
    localparam logic [16:0] MAX_BEATS = 17'(MAX_BURST);

    logic [16:0]   w_beats_left;
    logic [16:0]   w_limit;
    logic [16:0]   w_beats;
    logic [12:0]   w_room;
    logic [LB-1:0] w_rem;

    assign w_beats_left = ({1'b0, i_bytes_left} + 17'(BYTES - 1)) >> LB;
    assign w_room       = 13'(BOUNDARY_4K) - {1'b0, i_addr_lo};
    assign w_limit      = {4'b0, w_room >> LB};
    assign w_rem        = i_bytes_left[LB-1:0];

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_beats = w_beats_left;
        if (w_limit < w_beats)   w_beats = w_limit;
        if (MAX_BEATS < w_beats) w_beats = MAX_BEATS;
        o_last_wstrb = '0;
        for (int i = 0; i < BYTES; i++)
            o_last_wstrb[i] = (w_rem == '0) || (i < int'(w_rem));
    end

    assign o_awlen      = 4'(w_beats - 17'd1);
    assign o_last_burst = (w_beats == w_beats_left);

endmodule

// File: rtl/axi_mst_write_burst.sv
// AXI3 write master: drains a FWFT FIFO into a byte-length buffer in 4 KB-safe
// bursts, then optionally appends the CRC as a single strobed beat.
module axi_mst_write_burst
    import axi_mst_pkg::*;
#(
    parameter int         DATA_W    = 32,
    parameter int         MAX_BURST = 16,
    parameter logic [3:0] ID        = 4'h0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mst_begin,
    input  logic [31:0]         addr_dst,
    input  logic [15:0]         data_len,
    input  logic [2:0]          crc_mode,
    input  logic                en_data_crc,
    input  logic [31:0]         crc_data,
    input  logic                fifo_empty,
    input  logic [DATA_W-1:0]   fifo_in,
    output logic                en_read,
    output logic                busy,
    output logic                data_written,
    output logic                error,
    input  logic                awready,
    input  logic                wready,
    input  logic                bvalid,
    input  logic [3:0]          bid,
    input  logic [1:0]          bresp,
    output logic                awvalid,
    output logic                wvalid,
    output logic                wlast,
    output logic                bready,
    output logic [3:0]          awid,
    output logic [3:0]          wid,
    output logic [31:0]         awaddr,
    output logic [3:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic [1:0]          awlock,
    output logic [3:0]          awcache,
    output logic [2:0]          awprot,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb
);
    localparam int          BYTES      = DATA_W / 8;
    localparam int          LB         = $clog2(BYTES);
    localparam logic [31:0] ALIGN_MASK = ~32'(BYTES - 1);
    localparam logic [3:0]  BYTES_W    = 4'(BYTES);

    state_e             r_state, w_next;
    logic [31:0]        r_addr_dst, r_cur_addr, r_awaddr, r_crc_data;
    logic [15:0]        r_data_len, r_bytes_left;
    logic [2:0]         r_crc_mode;
    logic [3:0]         r_awlen, r_beat_cnt;
    logic               r_last_burst, r_crc_valid, r_error;
    logic [BYTES-1:0]   r_last_wstrb;

    logic [3:0]         w_calc_awlen;
    logic               w_calc_last;
    logic [BYTES-1:0]   w_calc_wstrb;
    logic [31:0]        w_crc_addr;
    logic [2:0]         w_nb;
    logic               w_crc_err, w_set_err, w_start, w_beat, w_final_beat;
    state_e             w_crc_state;
    logic [LB-1:0]      w_lane;
    logic [BYTES-1:0]   w_crc_base, w_crc_strb;
    logic [DATA_W-1:0]  w_crc_word;
    logic [15:0]        w_burst_bytes;
    logic               w_unused;

    axi_burst_calc #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) u_calc (
        .i_addr_lo    (r_cur_addr[11:0]),
        .i_bytes_left (r_bytes_left),
        .o_awlen      (w_calc_awlen),
        .o_last_burst (w_calc_last),
        .o_last_wstrb (w_calc_wstrb)
    );

    assign w_unused      = ^bid;
    assign w_start       = (r_state == S_IDLE) && mst_begin;
    assign w_beat        = (r_state == S_W) && !fifo_empty && wready;
    assign w_final_beat  = (r_beat_cnt == r_awlen);
    assign w_burst_bytes = 16'({1'b0, r_awlen} + 5'd1) << LB;

    // The CRC lands directly after the payload and must be naturally aligned.
    assign w_crc_addr  = r_addr_dst + {16'b0, r_data_len};
    assign w_nb        = crc_bytes(r_crc_mode);
    assign w_crc_err   = (w_nb != 3'd0) &&
                         (({1'b0, w_nb} > BYTES_W) || ((w_crc_addr[2:0] & (w_nb - 3'd1)) != 3'd0));
    assign w_crc_state = ((w_nb == 3'd0) || w_crc_err) ? S_DONE : S_CRC_WAIT;
    assign w_lane      = w_crc_addr[LB-1:0];
    assign w_crc_word  = DATA_W'(r_crc_data) << {w_lane, 3'b000};
    assign w_crc_strb  = w_crc_base << w_lane;

    always_comb begin
        w_crc_base = '0;
        for (int i = 0; i < BYTES; i++)
            w_crc_base[i] = (i < int'(w_nb));
    end

    always_comb begin
        w_next    = r_state;
        w_set_err = 1'b0;
        case (r_state)
            S_IDLE:     if (mst_begin) w_next = (addr_dst[LB-1:0] != '0) ? S_DONE : S_CALC;
            S_CALC: begin
                if (r_bytes_left == 16'd0) begin
                    w_next    = w_crc_state;
                    w_set_err = w_crc_err;
                end else begin
                    w_next = S_AW;
                end
            end
            S_AW:       if (awready) w_next = S_W;
            S_W:        if (w_beat && w_final_beat) w_next = S_B;
            S_B: begin
                if (bvalid) begin
                    if (bresp != AXI_RESP_OKAY) begin
                        w_next    = S_DONE;
                        w_set_err = 1'b1;
                    end else if (r_last_burst) begin
                        w_next    = w_crc_state;
                        w_set_err = w_crc_err;
                    end else begin
                        w_next = S_CALC;
                    end
                end
            end
            S_CRC_WAIT: if (r_crc_valid) w_next = S_CRC_AW;
            S_CRC_AW:   if (awready) w_next = S_CRC_W;
            S_CRC_W:    if (wready) w_next = S_CRC_B;
            S_CRC_B: begin
                if (bvalid) begin
                    w_next    = S_DONE;
                    w_set_err = (bresp != AXI_RESP_OKAY);
                end
            end
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr_dst   <= '0;
            r_cur_addr   <= '0;
            r_awaddr     <= '0;
            r_crc_data   <= '0;
            r_data_len   <= '0;
            r_bytes_left <= '0;
            r_crc_mode   <= CRC_MODE_NONE;
            r_awlen      <= '0;
            r_beat_cnt   <= '0;
            r_last_burst <= 1'b0;
            r_crc_valid  <= 1'b0;
            r_error      <= 1'b0;
            r_last_wstrb <= '0;
        end else begin
            if (w_start) begin
                r_addr_dst   <= addr_dst;
                r_cur_addr   <= addr_dst;
                r_data_len   <= data_len;
                r_bytes_left <= data_len;
                r_crc_mode   <= (crc_mode > CRC_MODE_32) ? CRC_MODE_NONE : crc_mode;
                r_error      <= (addr_dst[LB-1:0] != '0);
                r_crc_valid  <= 1'b0;
            end else begin
                if (w_set_err) r_error <= 1'b1;
                if (en_data_crc && r_state != S_IDLE) begin
                    r_crc_valid <= 1'b1;
                    r_crc_data  <= crc_data;
                end
            end

            if (r_state == S_CALC) begin
                r_awaddr     <= r_cur_addr;
                r_awlen      <= w_calc_awlen;
                r_last_burst <= w_calc_last;
                r_last_wstrb <= w_calc_wstrb;
                r_beat_cnt   <= '0;
            end

            if (w_beat) r_beat_cnt <= r_beat_cnt + 4'd1;

            if (r_state == S_B && bvalid && bresp == AXI_RESP_OKAY) begin
                r_cur_addr   <= r_cur_addr + {16'b0, w_burst_bytes};
                r_bytes_left <= r_last_burst ? 16'd0 : r_bytes_left - w_burst_bytes;
            end

            if (r_state == S_CRC_WAIT && r_crc_valid) begin
                r_awaddr <= w_crc_addr & ALIGN_MASK;
                r_awlen  <= 4'd0;
            end
        end
    end

    always_comb begin
        awvalid      = (r_state == S_AW) || (r_state == S_CRC_AW);
        wvalid       = 1'b0;
        wlast        = 1'b0;
        wdata        = '0;
        wstrb        = '0;
        bready       = (r_state == S_B) || (r_state == S_CRC_B);
        en_read      = w_beat;
        busy         = (r_state != S_IDLE) && (r_state != S_DONE);
        data_written = (r_state == S_DONE);
        if (r_state == S_W) begin
            wvalid = !fifo_empty;
            wlast  = !fifo_empty && w_final_beat;
            wdata  = fifo_in;
            wstrb  = (r_last_burst && w_final_beat) ? r_last_wstrb : '1;
        end else if (r_state == S_CRC_W) begin
            wvalid = 1'b1;
            wlast  = 1'b1;
            wdata  = w_crc_word;
            wstrb  = w_crc_strb;
        end
    end

    assign error   = r_error;
    assign awaddr  = r_awaddr;
    assign awlen   = r_awlen;
    assign awid    = ID;
    assign wid     = ID;
    assign awsize  = 3'(LB);
    assign awburst = AXI_BURST_INCR;
    assign awlock  = 2'b00;
    assign awcache = 4'b0011;
    assign awprot  = 3'b000;

endmodule

// File: tb/tb_axi_mst_write_burst.sv
// Directed bench for axi_mst_write_burst (DATA_W=32, MAX_BURST=16) with a
// cycle-stepped AXI slave / FIFO responder and hand-computed expectations.
module tb_axi_mst_write_burst;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mst_begin = 1'b0;
    logic [31:0] addr_dst = '0;
    logic [15:0] data_len = '0;
    logic [2:0]  crc_mode = '0;
    logic        en_data_crc = 1'b0;
    logic [31:0] crc_data = '0;
    logic        fifo_empty = 1'b1;
    logic [31:0] fifo_in = '0;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic [3:0]  bid = '0;
    logic [1:0]  bresp = '0;
    logic        en_read, busy, data_written, error;
    logic        awvalid, wvalid, wlast, bready;
    logic [3:0]  awid, wid, awlen, awcache;
    logic [31:0] awaddr, wdata;
    logic [2:0]  awsize, awprot;
    logic [1:0]  awburst, awlock;
    logic [3:0]  wstrb;

    axi_mst_write_burst #(.DATA_W(32), .MAX_BURST(16), .ID(4'h0)) dut (
        .clk(clk), .rst_n(rst_n), .mst_begin(mst_begin), .addr_dst(addr_dst),
        .data_len(data_len), .crc_mode(crc_mode), .en_data_crc(en_data_crc),
        .crc_data(crc_data), .fifo_empty(fifo_empty), .fifo_in(fifo_in),
        .en_read(en_read), .busy(busy), .data_written(data_written), .error(error),
        .awready(awready), .wready(wready), .bvalid(bvalid), .bid(bid), .bresp(bresp),
        .awvalid(awvalid), .wvalid(wvalid), .wlast(wlast), .bready(bready),
        .awid(awid), .wid(wid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .wdata(wdata), .wstrb(wstrb)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-transfer observations gathered by run_xfer.
    int          aw_n, beats, pop_idx, data_err, strb_err, wlast_err, pop_err, order_err;
    int          pulse_cyc, crc_aw_cyc, last_b_cyc;
    logic [31:0] aw_addr [16];
    logic [3:0]  aw_len  [16];
    logic [3:0]  last_strb, crc_strb;
    logic [31:0] crc_wdata;
    logic        done, busy_after, err_after, busy_at_done, err_at_done;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_xfer(input logic [31:0] addr, input logic [15:0] len, input logic [2:0] mode,
                            input logic [31:0] crc, input int crc_delay, input int err_b,
                            input bit fifo_gaps, input bit wrdy_rand);
        int exp_beats, burst_beat, cur_len, b_cnt, b_idx;
        bit in_burst, b_armed, pulse_done;
        exp_beats = (int'(len) + 3) / 4;
        aw_n = 0; beats = 0; pop_idx = 0; data_err = 0; strb_err = 0; wlast_err = 0;
        pop_err = 0; order_err = 0; pulse_cyc = -1; crc_aw_cyc = -1;
        last_strb = '0; crc_strb = '0; crc_wdata = '0;
        done = 1'b0; busy_after = 1'b0; err_after = 1'b1; busy_at_done = 1'b1; err_at_done = 1'b0;
        burst_beat = 0; cur_len = 0; b_cnt = 0; b_idx = 0;
        in_burst = 0; b_armed = 0; pulse_done = 0;
        last_b_cyc = (len == 16'd0) ? 0 : -1;
        @(negedge clk);
        addr_dst = addr; data_len = len; crc_mode = mode; mst_begin = 1'b1;
        @(negedge clk);
        mst_begin = 1'b0;
        for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
            fifo_empty = fifo_gaps && (cyc % 3 == 2);
            fifo_in    = 32'hC0DE_0000 + 32'(pop_idx);
            wready     = wrdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            awready    = 1'b1;
            if (b_armed && b_cnt > 0) b_cnt--;
            bvalid = b_armed && (b_cnt == 0);
            bresp  = (b_idx == err_b) ? 2'b11 : 2'b00;
            if (!pulse_done && ((crc_delay < 0 && cyc == 3) ||
                                (crc_delay >= 0 && last_b_cyc >= 0 && cyc == last_b_cyc + crc_delay))) begin
                en_data_crc = 1'b1; crc_data = crc; pulse_done = 1; pulse_cyc = cyc;
            end else begin
                en_data_crc = 1'b0; crc_data = 32'hDEAD_BEEF;
            end
            #1;
            if (cyc == 0) begin busy_after = busy; err_after = error; end
            if (awvalid && awready) begin
                if (in_burst) order_err++;
                if (aw_n < 16) begin aw_addr[aw_n] = awaddr; aw_len[aw_n] = awlen; end
                aw_n++; cur_len = int'(awlen); burst_beat = 0; in_burst = 1;
                if (beats >= exp_beats) crc_aw_cyc = cyc;
            end
            if (wvalid && !in_burst) order_err++;
            if (beats < exp_beats) begin
                if (wvalid && fifo_empty) pop_err++;
                if (en_read !== (wvalid && wready)) pop_err++;
            end else if (en_read) begin
                pop_err++;
            end
            if (wvalid && wready) begin
                if (beats < exp_beats) begin
                    if (wdata !== 32'hC0DE_0000 + 32'(pop_idx)) data_err++;
                    if (beats == exp_beats - 1) last_strb = wstrb;
                    else if (wstrb !== 4'hF) strb_err++;
                    pop_idx++;
                end else begin
                    crc_wdata = wdata; crc_strb = wstrb;
                end
                if (wlast !== (burst_beat == cur_len)) wlast_err++;
                if (burst_beat == cur_len) begin b_armed = 1; b_cnt = 2; end
                burst_beat++; beats++;
            end
            if (bvalid && bready) begin
                b_armed = 0; in_burst = 0; b_idx++;
                if (beats >= exp_beats && last_b_cyc < 0) last_b_cyc = cyc;
            end
            if (data_written) begin done = 1'b1; busy_at_done = busy; err_at_done = error; end
            @(negedge clk);
        end
        en_data_crc = 1'b0; bvalid = 1'b0; wready = 1'b0; awready = 1'b0; fifo_empty = 1'b1;
    endtask

    logic seen_w;
    logic ctrl_activity;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("reset_ctrl", {awvalid, wvalid, wlast, bready, en_read, busy, data_written, error}, 8'h00);
        check("reset_addr", awaddr, 32'h0);
        check("reset_len_strb", {awlen, wstrb}, 8'h00);
        check("reset_wdata", wdata, 32'h0);
        rst_n = 1'b1;

        // 64 bytes at 0x1000, no CRC: one full burst
        run_xfer(32'h1000, 16'd64, 3'b000, 32'h0, 0, -1, 0, 0);
        check("t1_done", done, 1);
        check("t1_busy_after_start", busy_after, 1);
        check("t1_busy_at_done", busy_at_done, 0);
        check("t1_aw_n", aw_n, 1);
        check("t1_awaddr", aw_addr[0], 32'h1000);
        check("t1_awlen", aw_len[0], 4'd15);
        check("t1_beats", beats, 16);
        check("t1_last_strb", last_strb, 4'hF);
        check("t1_errs", {strb_err, wlast_err, data_err, pop_err, order_err}, 0);
        check("t1_error", err_at_done, 0);
        check("t1_consts", {awid, wid, awsize, awburst, awlock, awcache, awprot}, {4'h0, 4'h0, 3'd2, 2'b01, 2'b00, 4'b0011, 3'b000});

        // 333 bytes + CRC8, CRC pulse arrives early during the payload
        run_xfer(32'h0, 16'd333, 3'b001, 32'h1234_56A5, -1, -1, 0, 0);
        check("t2_done", done, 1);
        check("t2_aw_n", aw_n, 7);
        check("t2_aw4", {aw_addr[4], aw_len[4]}, {32'h100, 4'd15});
        check("t2_aw5", {aw_addr[5], aw_len[5]}, {32'h140, 4'd3});
        check("t2_crc_aw", {aw_addr[6], aw_len[6]}, {32'h14C, 4'd0});
        check("t2_beats", beats, 85);
        check("t2_last_strb", last_strb, 4'h1);
        check("t2_crc_strb", crc_strb, 4'h2);
        check("t2_crc_byte", crc_wdata & 32'h0000_FF00, 32'h0000_A500);
        check("t2_errs", {strb_err, wlast_err, data_err, pop_err, order_err}, 0);
        check("t2_error", err_at_done, 0);

        // 4 KB boundary split
        run_xfer(32'h0FF0, 16'd64, 3'b000, 32'h0, 0, -1, 0, 0);
        check("t3_aw_n", aw_n, 2);
        check("t3_aw0", {aw_addr[0], aw_len[0]}, {32'h0FF0, 4'd3});
        check("t3_aw1", {aw_addr[1], aw_len[1]}, {32'h1000, 4'd11});
        check("t3_beats", beats, 16);
        check("t3_errs", {wlast_err, data_err, order_err, 29'd0, err_at_done}, 0);

        // CRC16 arriving 50 cycles after the last B
        run_xfer(32'h100, 16'd6, 3'b010, 32'h1234_BEEF, 50, -1, 0, 0);
        check("t4_done", done, 1);
        check("t4_aw0", {aw_addr[0], aw_len[0]}, {32'h100, 4'd1});
        check("t4_last_strb", last_strb, 4'h3);
        check("t4_crc_aw", {aw_addr[1], aw_len[1]}, {32'h104, 4'd0});
        check("t4_crc_strb", crc_strb, 4'hC);
        check("t4_crc_data", crc_wdata & 32'hFFFF_0000, 32'hBEEF_0000);
        check("t4_waited", (crc_aw_cyc > pulse_cyc) && (crc_aw_cyc >= last_b_cyc + 50), 1);
        check("t4_error", err_at_done, 0);

        // SLVERR-class response on the first B aborts everything
        run_xfer(32'h0, 16'd333, 3'b001, 32'h55, -1, 0, 0, 0);
        check("t5_done", done, 1);
        check("t5_aw_n", aw_n, 1);
        check("t5_beats", beats, 16);
        check("t5_error", err_at_done, 1);
        run_xfer(32'h1000, 16'd8, 3'b000, 32'h0, 0, -1, 0, 0);
        check("t5_error_cleared", err_after, 0);
        check("t5_next_ok", {done, err_at_done}, 2'b10);

        // FIFO gaps and random wready
        run_xfer(32'h2000, 16'd100, 3'b000, 32'h0, 0, -1, 1, 1);
        check("t6_done", done, 1);
        check("t6_aw1", {aw_addr[1], aw_len[1]}, {32'h2040, 4'd8});
        check("t6_beats", beats, 25);
        check("t6_pop", pop_err, 0);
        check("t6_wlast", wlast_err, 0);
        check("t6_data", {data_err, strb_err}, 0);
        check("t6_last_strb", last_strb, 4'hF);

        // Misaligned destination: error, no AXI traffic
        run_xfer(32'h102, 16'd8, 3'b000, 32'h0, 0, -1, 0, 0);
        check("t7_done", done, 1);
        check("t7_traffic", {aw_n, beats}, 0);
        check("t7_error", err_at_done, 1);

        // CRC32 would land at 0x5: payload written, CRC refused
        run_xfer(32'h0, 16'd5, 3'b011, 32'h0, 0, -1, 0, 0);
        check("t8_aw_n", aw_n, 1);
        check("t8_beats", beats, 2);
        check("t8_last_strb", last_strb, 4'h1);
        check("t8_error", {done, err_at_done}, 2'b11);

        // Zero-length payload with CRC32 only
        run_xfer(32'h200, 16'd0, 3'b011, 32'hCAFE_F00D, 0, -1, 0, 0);
        check("t9_aw", {aw_n, aw_addr[0], aw_len[0]}, {32'd1, 32'h200, 4'd0});
        check("t9_crc", {crc_strb, crc_wdata}, {4'hF, 32'hCAFE_F00D});
        check("t9_pop", pop_err, 0);
        check("t9_error", {done, err_at_done}, 2'b10);

        // Reset while stalled in W
        @(negedge clk);
        addr_dst = 32'h3000; data_len = 16'd64; crc_mode = 3'b000; mst_begin = 1'b1;
        awready = 1'b1; wready = 1'b0; fifo_empty = 1'b0;
        @(negedge clk);
        mst_begin = 1'b0;
        seen_w = 1'b0;
        for (int i = 0; i < 20 && !seen_w; i++) begin
            @(negedge clk);
            #1;
            if (wvalid) seen_w = 1'b1;
        end
        check("t10_in_w", seen_w, 1);
        rst_n = 1'b0;
        #1;
        check("t10_rst_ctrl", {awvalid, wvalid, wlast, bready, en_read, busy, data_written, error}, 8'h00);
        check("t10_rst_aw", {awaddr, awlen}, 36'h0);
        check("t10_rst_w", {wdata, wstrb}, 36'h0);
        wready = 1'b1;
        ctrl_activity = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            ctrl_activity = ctrl_activity | awvalid | wvalid | en_read | busy | data_written;
        end
        check("t10_abandoned", ctrl_activity, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
